jk_reg_bank: RTL and testbench
==============================

# jk_reg_bank

Parametrised bank of WIDTH master-slave flip-flops with a per-cycle selectable next-state mode: JK, D, T or SR. It is the general-purpose storage element for control and status registers in the design. A master register computes the next state each enabled clock; a SLAVE_STAGES-deep slave pipeline presents it on q/q_bar. The bank also flags illegal SR inputs and counts master state-change events.

## Interface
- WIDTH, 8: number of flip-flop channels; must be ≥1.
- SLAVE_STAGES, 1: slave pipeline depth, legal range 1..4; any other value is an elaboration error.
- CNT_W, 8: width of the change-event counter; must be ≥1.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  master update enable.
- clr  in  1  synchronous clear of master and counter; overrides en.
- mode  in  2  next-state mode: 00 JK, 01 D, 10 T, 11 SR. Applies to all channels in the current cycle.
- j  in  WIDTH  J / D / T / S input per channel.
- k  in  WIDTH  K / R input per channel; ignored in D and T modes.
- err_clr  in  1  clears sr_err.
- q  out  WIDTH  slave output.
- q_bar  out  WIDTH  registered complement of q.
- sr_err  out  1  sticky illegal-SR flag.
- chg_cnt  out  CNT_W  saturating count of master change cycles.

## Operation
- **Reset values** (rst=1, immediate and asynchronous):
  - master m=0 and all slave stages 0;
  - q=0, q_bar=all ones;
  - sr_err=0, chg_cnt=0.
- **Master priority:** clr=1 → m<=0 and chg_cnt<=0. Otherwise en=0 → m holds. Otherwise per-bit next state by mode:
  - JK: jk=00 hold, 10 set, 01 reset, 11 toggle.
  - D: m<=j.
  - T: m<=m^j.
  - SR: 00 hold, 10 set, 01 reset, 11 hold that bit and raise the illegal flag.
- **sr_err:**
  - Set on a clock where en=1, clr=0, mode=11 and any bit has j&k=1.
  - Cleared by err_clr=1. If clear and set occur in the same cycle, set wins.
  - Not affected by clr.
  - A cycle with en=0 never sets the flag.
- **chg_cnt:**
  - Increments by 1 on a clock where en=1, clr=0 and the computed next m ≠ current m (any bit changes).
  - Saturates at 2^CNT_W−1; it never wraps.
  - A cycle where every bit holds does not count.
- **Slave pipeline:**
  - Stage 1 captures m on every clock, independent of en and clr.
  - Stage i captures stage i−1.
  - q = last stage; q_bar = ~(last stage), registered on the same edge.
  - Invariant: q_bar == ~q in every cycle after reset.
- **Reset mid-operation:** rst asserted at any time clears every register at once, including in-flight slave stages. The first post-reset edge with en=1 operates from m=0.

## Timing
- Inputs are sampled on rising edge N; m holds the new value after edge N.
- q/q_bar show that value after edge N+SLAVE_STAGES:
  - SLAVE_STAGES=1: the input at edge N is visible after edge N+1 (2-edge input-to-output path, master-slave behaviour).
- sr_err and chg_cnt update after edge N; they are not delayed by the slave pipeline.
- clr at edge N: m=0 after N, and q=0 after N+SLAVE_STAGES. Earlier m values continue to drain from the slave stages until then.
- No combinational path from any input to any output.

## Test plan
- **Reset:** WIDTH=8, assert rst mid-stream with q=0xA5 → q=0x00, q_bar=0xFF, sr_err=0, chg_cnt=0 immediately, without waiting for a clock edge.
- **JK modes:** SLAVE_STAGES=1, mode=00, en=1.
  - j=0xF0, k=0x0F → m=0xF0, then q=0xF0 one edge later.
  - Next j=k=0xFF → m=0x0F.
  - Next j=k=0x00 → hold; chg_cnt=2.
- **D/T/en:**
  - mode=01, j=0x3C → m=0x3C.
  - mode=10, j=0x01 → m=0x3D.
  - en=0 with mode=10, j=0xFF → m stays 0x3D, chg_cnt unchanged.
- **SR illegal:**
  - mode=11, j=0x81, k=0x01 with m=0x00 → bit7 set, bit0 held; m=0x80, sr_err=1.
  - err_clr alone → sr_err=0.
  - err_clr plus another illegal input in the same cycle → sr_err stays 1.
- **Pipeline depth:** SLAVE_STAGES=4, D mode, j=0x55 at edge N then 0xAA at edge N+1 → q=0x55 after edge N+4 and 0xAA after edge N+5. clr at edge N+2 → q=0x00 after edge N+6.
- **Counter saturation:** CNT_W=3, toggle bit0 in T mode for 10 cycles → chg_cnt reads 1..7, then stays 7. clr → chg_cnt=0.

Source files
------------

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - WIDTH-channel master-slave JK/D/T/SR flip-flop bank with SR error flag and change counter
module jk_reg_bank #(
    parameter int WIDTH        = 8,
    parameter int SLAVE_STAGES = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    generate
        if (SLAVE_STAGES < 1 || SLAVE_STAGES > 4) begin : g_bad_stages
            $error("jk_reg_bank: SLAVE_STAGES must be in 1..4");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("jk_reg_bank: WIDTH must be at least 1");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("jk_reg_bank: CNT_W must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] m_next;
    logic             sr_illegal;
    logic             upd;
    logic             changed;

    logic [WIDTH-1:0] stage [SLAVE_STAGES];
    logic [WIDTH-1:0] last_in;
    logic [WIDTH-1:0] q_bar_r;

    assign upd     = en && !clr;
    assign changed = upd && (m_next != m);

    // Per-bit next master state for the selected mode; illegal SR bits hold
    always_comb begin
        m_next     = m;
        sr_illegal = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            unique case (mode)
                MODE_JK: begin
                    unique case ({j[b], k[b]})
                        2'b10:   m_next[b] = 1'b1;
                        2'b01:   m_next[b] = 1'b0;
                        2'b11:   m_next[b] = ~m[b];
                        default: m_next[b] = m[b];
                    endcase
                end
                MODE_D:  m_next[b] = j[b];
                MODE_T:  m_next[b] = m[b] ^ j[b];
                MODE_SR: begin
                    unique case ({j[b], k[b]})
                        2'b10:   m_next[b] = 1'b1;
                        2'b01:   m_next[b] = 1'b0;
                        2'b11: begin
                            m_next[b]  = m[b];
                            sr_illegal = 1'b1;
                        end
                        default: m_next[b] = m[b];
                    endcase
                end
                default: m_next[b] = m[b];
            endcase
        end
    end

    // Master register: clear beats enable, enable loads the computed state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
        end else if (clr) begin
            m <= '0;
        end else if (en) begin
            m <= m_next;
        end
    end

    // Saturating count of enabled cycles in which the master actually changed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_cnt <= '0;
        end else if (clr) begin
            chg_cnt <= '0;
        end else if (changed && chg_cnt != CNT_MAX) begin
            chg_cnt <= chg_cnt + CNT_W'(1);
        end
    end

    // Sticky illegal-SR flag; a new violation outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_err <= 1'b0;
        end else if (upd && mode == MODE_SR && sr_illegal) begin
            sr_err <= 1'b1;
        end else if (err_clr) begin
            sr_err <= 1'b0;
        end
    end

    generate
        if (SLAVE_STAGES == 1) begin : g_last_in_m
            assign last_in = m;
        end else begin : g_last_in_stage
            assign last_in = stage[SLAVE_STAGES-2];
        end
    endgenerate

    // Slave pipeline runs every clock; q_bar is loaded with the complement of what the last stage loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLAVE_STAGES; i++) begin
                stage[i] <= '0;
            end
            q_bar_r <= '1;
        end else begin
            stage[0] <= m;
            for (int i = 1; i < SLAVE_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            q_bar_r <= ~last_in;
        end
    end

    assign q     = stage[SLAVE_STAGES-1];
    assign q_bar = q_bar_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - directed table-driven bench for jk_reg_bank
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = 8'h00;
    logic [7:0] k = 8'h00;
    logic       err_clr = 1'b0;

    logic [7:0] q_a, q_bar_a, cnt_a;
    logic       err_a;
    logic [7:0] q_b, q_bar_b;
    logic [2:0] cnt_b;
    logic       err_b;

    int errors = 0;
    int checks = 0;

    jk_reg_bank #(.WIDTH(8), .SLAVE_STAGES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .j(j), .k(k),
        .err_clr(err_clr), .q(q_a), .q_bar(q_bar_a), .sr_err(err_a), .chg_cnt(cnt_a)
    );

    jk_reg_bank #(.WIDTH(8), .SLAVE_STAGES(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .j(j), .k(k),
        .err_clr(err_clr), .q(q_b), .q_bar(q_bar_b), .sr_err(err_b), .chg_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       err_clr;
        logic [1:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] exp_m;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic c, input logic ec, input logic [1:0] md,
                         input logic [7:0] jv, input logic [7:0] kv);
        en = e; clr = c; err_clr = ec; mode = md; j = jv; k = kv;
    endtask

    initial begin
        logic [7:0] prev_m;
        logic [2:0] exp_sat;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hF0, 8'h0F, 8'hF0, 1'b0, 8'd1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 8'h0F, 1'b0, 8'd2};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h0F, 1'b0, 8'd2};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 8'h3C, 8'h00, 8'h3C, 1'b0, 8'd3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'b10, 8'h01, 8'h00, 8'h3D, 1'b0, 8'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b10, 8'hFF, 8'h00, 8'h3D, 1'b0, 8'd4};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0, 8'd5};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h81, 8'h01, 8'h80, 1'b1, 8'd6};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'h80, 1'b0, 8'd6};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 8'h80, 1'b1, 8'd6};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h02, 8'h80, 8'h02, 1'b1, 8'd7};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'd0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h01, 8'h00, 8'h01, 1'b0, 8'd1};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_q", q_a, 8'h00);
        check("rst_q_bar", q_bar_a, 8'hFF);
        check("rst_err", {7'b0, err_a}, 8'h00);
        check("rst_cnt", cnt_a, 8'h00);
        check("rst_q_bar_b", q_bar_b, 8'hFF);
        rst = 1'b0;

        // table: q shows the previous row's master value one edge later
        prev_m = 8'h00;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].err_clr, tbl[i].mode, tbl[i].j, tbl[i].k);
            step();
            check($sformatf("v%0d_q", i), q_a, prev_m);
            check($sformatf("v%0d_q_bar", i), q_bar_a, ~prev_m);
            check($sformatf("v%0d_err", i), {7'b0, err_a}, {7'b0, tbl[i].exp_err});
            check($sformatf("v%0d_cnt", i), cnt_a, tbl[i].exp_cnt);
            prev_m = tbl[i].exp_m;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("tbl_last_q", q_a, prev_m);

        // asynchronous reset mid-stream with q=A5, sr_err=1, chg_cnt>0
        drive(1'b1, 1'b0, 1'b0, 2'b01, 8'hA5, 8'h00);
        step();
        drive(1'b1, 1'b0, 1'b0, 2'b11, 8'h01, 8'h01);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("pre_rst_q", q_a, 8'hA5);
        check("pre_rst_err", {7'b0, err_a}, 8'h01);
        check("pre_rst_cnt", cnt_a, 8'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", q_a, 8'h00);
        check("async_rst_q_bar", q_bar_a, 8'hFF);
        check("async_rst_err", {7'b0, err_a}, 8'h00);
        check("async_rst_cnt", cnt_a, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b10, 8'h01, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("post_rst_q", q_a, 8'h01);
        check("post_rst_cnt", cnt_a, 8'd1);

        // four-stage slave pipeline with clr draining
        rst = 1'b1; #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b01, 8'h55, 8'h00);
        step();
        check("pipe_n0", q_b, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 2'b01, 8'hAA, 8'h00);
        step();
        check("pipe_n1", q_b, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00);
        step();
        check("pipe_n2", q_b, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("pipe_n3", q_b, 8'h00);
        step();
        check("pipe_n4", q_b, 8'h55);
        check("pipe_n4_bar", q_bar_b, 8'hAA);
        step();
        check("pipe_n5", q_b, 8'hAA);
        check("pipe_n5_bar", q_bar_b, 8'h55);
        step();
        check("pipe_n6", q_b, 8'h00);
        check("pipe_n6_bar", q_bar_b, 8'hFF);

        // 3-bit counter saturation
        rst = 1'b1; #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b10, 8'h01, 8'h00);
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_sat = (c > 7) ? 3'd7 : 3'(c);
            check($sformatf("sat_%0d", c), {5'b0, cnt_b}, {5'b0, exp_sat});
        end
        drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("sat_clr", {5'b0, cnt_b}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
